interface_hcsr04: RTL

INTERFACE_HCSR04 -- requirements
Module: interface_hcsr04

---
 rtl/neurosync_pkg.sv | 52 +++++
 rtl/contador_bcd_3d.sv | 38 +++
 rtl/interface_hcsr04.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/neurosync_pkg.sv
// -----------------------------------------------------------------------------
// neurosync_pkg
// Shared definitions for the HC-SR04 ultrasonic sensor interface:
//   - default timing constants (50 MHz system clock)
//   - FSM state encoding (also exported on db_estado)
//   - saturating three-digit BCD increment helper
// -----------------------------------------------------------------------------
package neurosync_pkg;

    // 10 us trigger pulse at 50 MHz
    localparam int CICLOS_TRIGGER_PADRAO = 500;
    // 58.82 us of echo per centimetre at 50 MHz
    localparam int CICLOS_CM_PADRAO      = 2941;
    // 30 ms maximum from trigger end to echo fall at 50 MHz
    localparam int CICLOS_TIMEOUT_PADRAO = 1_500_000;

    // Largest value representable by the three BCD digits
    localparam logic [11:0] BCD_MAXIMO = 12'h999;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        CONTA       = 4'd4,
        ARREDONDA   = 4'd5,
        FINAL       = 4'd6,
        ERRO        = 4'd7
    } estado_t;

    // Adds one to a {centenas, dezenas, unidades} BCD value; 999 stays 999.
    function automatic logic [11:0] bcd_inc_sat(input logic [11:0] valor);
        logic [3:0]  uni;
        logic [3:0]  dez;
        logic [3:0]  cen;
        logic [11:0] res;
        uni = valor[3:0];
        dez = valor[7:4];
        cen = valor[11:8];
        if (valor == BCD_MAXIMO) begin
            res = valor;
        end else if (uni != 4'd9) begin
            res = {cen, dez, uni + 4'd1};
        end else if (dez != 4'd9) begin
            res = {cen, dez + 4'd1, 4'd0};
        end else begin
            res = {cen + 4'd1, 4'd0, 4'd0};
        end
        return res;
    endfunction

endpackage

// File: rtl/contador_bcd_3d.sv
// -----------------------------------------------------------------------------
// contador_bcd_3d
// Three-digit BCD counter that saturates at 999 instead of wrapping.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset (clears to 000)
//   zera   - synchronous clear (has priority over conta)
//   conta  - increment by one when high
//   bcd    - registered count {centenas, dezenas, unidades}
// -----------------------------------------------------------------------------
module contador_bcd_3d
    import neurosync_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    output logic [11:0] bcd
);

    logic [11:0] bcd_r;

    // Count register: clear, saturating increment or hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd_r <= 12'h000;
        end else if (zera) begin
            bcd_r <= 12'h000;
        end else if (conta) begin
            bcd_r <= bcd_inc_sat(bcd_r);
        end else begin
            bcd_r <= bcd_r;
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/interface_hcsr04.sv
// -----------------------------------------------------------------------------
// interface_hcsr04
// Drives an HC-SR04 ultrasonic sensor: on a medir request it issues a trigger
// pulse, measures the echo high time and reports the distance in centimetres
// as three BCD digits.
//
// Build option: define MEDIDA_ARREDONDA_EN to round the result to the nearest
// centimetre (residual >= CICLOS_CM/2 adds one); otherwise the count is
// truncated.
//
// Parameters:
//   CICLOS_TRIGGER - trigger pulse width in clocks
//   CICLOS_CM      - clocks of echo per centimetre
//   CICLOS_TIMEOUT - maximum clocks from trigger end to echo fall
// Ports:
//   clock     - system clock (50 MHz nominal)
//   reset     - asynchronous active-low reset
//   medir     - single-cycle start request (ignored unless idle)
//   echo      - asynchronous sensor echo
//   trigger   - sensor trigger pulse
//   medida    - last valid distance, BCD {centenas, dezenas, unidades}
//   pronto    - one-cycle pulse when medida is updated
//   timeout   - one-cycle pulse when a measurement is aborted
//   db_estado - current FSM state
// -----------------------------------------------------------------------------
module interface_hcsr04
    import neurosync_pkg::*;
#(
    parameter int CICLOS_TRIGGER = CICLOS_TRIGGER_PADRAO,
    parameter int CICLOS_CM      = CICLOS_CM_PADRAO,
    parameter int CICLOS_TIMEOUT = CICLOS_TIMEOUT_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    // One cycle counter serves both the trigger width and the per-cm count
    localparam int CICLO_MAX = (CICLOS_TRIGGER > CICLOS_CM) ? CICLOS_TRIGGER : CICLOS_CM;
    localparam int CW        = $clog2(CICLO_MAX + 1);
    localparam int TW        = $clog2(CICLOS_TIMEOUT + 1);

    localparam logic [CW-1:0] TRIG_FIM = CW'(CICLOS_TRIGGER - 1);
    localparam logic [CW-1:0] CM_FIM   = CW'(CICLOS_CM - 1);
    localparam logic [TW-1:0] TOUT_FIM = TW'(CICLOS_TIMEOUT - 1);
`ifdef MEDIDA_ARREDONDA_EN
    localparam logic [CW-1:0] MEIO_CM  = CW'(CICLOS_CM / 2);
`endif

    logic          echo_meta_r;
    logic          echo_sync_r;
    logic          echo_ant_r;
    logic          sobe_s;
    logic          desce_s;

    estado_t       estado_r;
    logic [CW-1:0] ciclo_r;
    logic [TW-1:0] tout_r;
    logic          trigger_r;
    logic          pronto_r;
    logic          timeout_r;
    logic [11:0]   medida_r;

    logic [11:0]   bcd_s;
    logic          zera_s;
    logic          conta_s;
    logic [11:0]   resultado_s;

    // Two-flop synchroniser for echo plus a delayed copy for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta_r <= 1'b0;
            echo_sync_r <= 1'b0;
            echo_ant_r  <= 1'b0;
        end else begin
            echo_meta_r <= echo;
            echo_sync_r <= echo_meta_r;
            echo_ant_r  <= echo_sync_r;
        end
    end

    // Edges of the synchronised echo only
    always_comb begin
        sobe_s  = echo_sync_r & ~echo_ant_r;
        desce_s = ~echo_sync_r & echo_ant_r;
    end

    // BCD counter control: cleared in PREPARA, advanced on each cm wrap
    always_comb begin
        zera_s  = 1'b0;
        conta_s = 1'b0;
        if (estado_r == PREPARA) begin
            zera_s = 1'b1;
        end else if ((estado_r == CONTA) && (ciclo_r == CM_FIM)) begin
            conta_s = 1'b1;
        end else begin
            zera_s  = 1'b0;
            conta_s = 1'b0;
        end
    end

    // Final value presented in ARREDONDA (residual is ciclo_r at that point)
    always_comb begin
        resultado_s = bcd_s;
`ifdef MEDIDA_ARREDONDA_EN
        if (ciclo_r >= MEIO_CM) begin
            resultado_s = bcd_inc_sat(bcd_s);
        end else begin
            resultado_s = bcd_s;
        end
`endif
    end

    contador_bcd_3d u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera_s),
        .conta (conta_s),
        .bcd   (bcd_s)
    );

    // Measurement FSM with registered outputs; pronto is high during FINAL,
    // timeout is high during ERRO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r  <= INICIAL;
            ciclo_r   <= {CW{1'b0}};
            tout_r    <= {TW{1'b0}};
            trigger_r <= 1'b0;
            pronto_r  <= 1'b0;
            timeout_r <= 1'b0;
            medida_r  <= 12'h000;
        end else begin
            pronto_r  <= 1'b0;
            timeout_r <= 1'b0;
            case (estado_r)
                INICIAL: begin
                    if (medir) begin
                        estado_r <= PREPARA;
                    end else begin
                        estado_r <= INICIAL;
                    end
                end
                PREPARA: begin
                    ciclo_r   <= {CW{1'b0}};
                    tout_r    <= {TW{1'b0}};
                    trigger_r <= 1'b1;
                    estado_r  <= TRIGGER;
                end
                TRIGGER: begin
                    if (ciclo_r == TRIG_FIM) begin
                        // timeout window starts at trigger exit
                        ciclo_r   <= {CW{1'b0}};
                        tout_r    <= {TW{1'b0}};
                        trigger_r <= 1'b0;
                        estado_r  <= ESPERA_ECHO;
                    end else begin
                        ciclo_r <= ciclo_r + CW'(1);
                    end
                end
                ESPERA_ECHO: begin
                    if (tout_r == TOUT_FIM) begin
                        timeout_r <= 1'b1;
                        estado_r  <= ERRO;
                    end else begin
                        tout_r <= tout_r + TW'(1);
                        if (sobe_s) begin
                            estado_r <= CONTA;
                        end else begin
                            estado_r <= ESPERA_ECHO;
                        end
                    end
                end
                CONTA: begin
                    // every cycle spent here, including the one seeing the
                    // fall, is one clock of echo high time
                    if (ciclo_r == CM_FIM) begin
                        ciclo_r <= {CW{1'b0}};
                    end else begin
                        ciclo_r <= ciclo_r + CW'(1);
                    end
                    if (tout_r == TOUT_FIM) begin
                        timeout_r <= 1'b1;
                        estado_r  <= ERRO;
                    end else begin
                        tout_r <= tout_r + TW'(1);
                        if (desce_s) begin
                            estado_r <= ARREDONDA;
                        end else begin
                            estado_r <= CONTA;
                        end
                    end
                end
                ARREDONDA: begin
                    medida_r <= resultado_s;
                    pronto_r <= 1'b1;
                    estado_r <= FINAL;
                end
                FINAL: begin
                    estado_r <= INICIAL;
                end
                ERRO: begin
                    estado_r <= INICIAL;
                end
                default: begin
                    trigger_r <= 1'b0;
                    estado_r  <= INICIAL;
                end
            endcase
        end
    end

    assign trigger   = trigger_r;
    assign pronto    = pronto_r;
    assign timeout   = timeout_r;
    assign medida    = medida_r;
    assign db_estado = estado_r;

endmodule
